// File: rtl/sync_cond_pkg.sv
// Shared constants for the sync conditioner: phase-counter width and default tuning.
package sync_cond_pkg;

    localparam int unsigned CNT_W               = 24;
    localparam int unsigned FILT_CNT_W          = 4;
    localparam int unsigned DEFAULT_FILTER_LEN  = 4;
    localparam int unsigned DEFAULT_ACT_TIMEOUT = 2_000_000;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/sync_channel.sv
// One sync channel: 2-flop synchroniser, glitch filter, activity watchdog and, when
// SYNC_POLARITY_AUTO_EN is defined, automatic polarity detection from phase lengths.
module sync_channel
    import sync_cond_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = DEFAULT_FILTER_LEN,
    parameter int unsigned ACT_TIMEOUT = DEFAULT_ACT_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic sync_o,
    output logic fall_o,
    output logic pol_o,
    output logic act_o
);

    localparam int unsigned IdleW = $clog2(ACT_TIMEOUT + 1);
    localparam logic [FILT_CNT_W-1:0] FiltLast = FILT_CNT_W'(FILTER_LEN - 1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(ACT_TIMEOUT - 1);

    logic                  meta_q, sync_q;
    logic                  filt_q, filt_d;
    logic [FILT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  primed_q, primed_d;
    logic                  act_q, act_d;
    logic [IdleW-1:0]      idle_q, idle_d;
    logic                  out_last_q;
    logic                  out_w, edge_w, pol_w;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            filt_q     <= 1'b0;
            cnt_q      <= '0;
            primed_q   <= 1'b0;
            act_q      <= 1'b0;
            idle_q     <= '0;
            out_last_q <= 1'b1;
        end else begin
            meta_q     <= raw_i;
            sync_q     <= meta_q;
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            primed_q   <= primed_d;
            act_q      <= act_d;
            idle_q     <= idle_d;
            out_last_q <= out_w;
        end
    end

    // Until primed, the filter simply tracks the synchroniser so the post-reset
    // settling of the input is never reported as an edge.
    always_comb begin
        filt_d   = filt_q;
        cnt_d    = cnt_q;
        primed_d = primed_q;
        if (!primed_q) begin
            filt_d = sync_q;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == FiltLast) begin
                primed_d = 1'b1;
                cnt_d    = '0;
            end
        end else if (sync_q != filt_q) begin
            if (cnt_q == FiltLast) begin
                filt_d = sync_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign edge_w = primed_q && (filt_d != filt_q);

    always_comb begin
        act_d  = act_q;
        idle_d = idle_q;
        if (edge_w) begin
            act_d  = 1'b1;
            idle_d = '0;
        end else if (act_q) begin
            if (idle_q == IdleLast) begin
                act_d  = 1'b0;
                idle_d = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

`ifdef SYNC_POLARITY_AUTO_EN
    logic [CNT_W-1:0] run_q, run_d, high_len_q, high_len_d;
    logic             high_vld_q, high_vld_d;
    logic             cand_q, cand_d, cand_vld_q, cand_vld_d;
    logic             pol_q, pol_d;
    logic             cand_w;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q      <= '0;
            high_len_q <= '0;
            high_vld_q <= 1'b0;
            cand_q     <= 1'b0;
            cand_vld_q <= 1'b0;
            pol_q      <= 1'b0;
        end else begin
            run_q      <= run_d;
            high_len_q <= high_len_d;
            high_vld_q <= high_vld_d;
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
            pol_q      <= pol_d;
        end
    end

    // At a rising edge run_q holds the just-completed low phase length.
    assign cand_w = high_len_q < run_q;

    always_comb begin
        run_d      = (run_q == CNT_MAX) ? run_q : run_q + 1'b1;
        high_len_d = high_len_q;
        high_vld_d = high_vld_q;
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
        pol_d      = pol_q;
        if (!act_q) begin
            run_d      = '0;
            high_vld_d = 1'b0;
            cand_vld_d = 1'b0;
        end
        if (edge_w) begin
            run_d = CNT_W'(1);
            // A phase is only complete if it began at an edge we observed.
            if (act_q) begin
                if (filt_q) begin
                    high_len_d = run_q;
                    high_vld_d = 1'b1;
                end else if (high_vld_q) begin
                    cand_d     = cand_w;
                    cand_vld_d = 1'b1;
                    if (cand_vld_q && (cand_q == cand_w) && (cand_w != pol_q)) begin
                        pol_d = cand_w;
                    end
                end
            end
        end
    end

    assign pol_w = pol_q;
`else
    assign pol_w = 1'b0;
`endif

    assign out_w  = act_q ? (filt_q ^ pol_w) : 1'b1;
    assign sync_o = out_w;
    assign fall_o = out_last_q & ~out_w;
    assign pol_o  = pol_w;
    assign act_o  = act_q;

endmodule

// File: rtl/sync_conditioner.sv
// H/V sync conditioner: two independent sync_channel instances producing active-low
// syncs, leading-edge strobes, polarity and activity. SYNC_POLARITY_AUTO_EN enables
// automatic polarity detection.
module sync_conditioner
    import sync_cond_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = DEFAULT_FILTER_LEN,
    parameter int unsigned ACT_TIMEOUT = DEFAULT_ACT_TIMEOUT
) (
    input  logic clk_50mhz_in,
    input  logic rst_in,
    input  logic hsync_raw_in,
    input  logic vsync_raw_in,
    output logic hsync_out,
    output logic vsync_out,
    output logic hsync_fall_out,
    output logic vsync_fall_out,
    output logic hsync_pol_out,
    output logic vsync_pol_out,
    output logic hsync_act_out,
    output logic vsync_act_out
);

    sync_channel #(
        .FILTER_LEN (FILTER_LEN),
        .ACT_TIMEOUT(ACT_TIMEOUT)
    ) u_hsync (
        .clk_i (clk_50mhz_in),
        .rst_i (rst_in),
        .raw_i (hsync_raw_in),
        .sync_o(hsync_out),
        .fall_o(hsync_fall_out),
        .pol_o (hsync_pol_out),
        .act_o (hsync_act_out)
    );

    sync_channel #(
        .FILTER_LEN (FILTER_LEN),
        .ACT_TIMEOUT(ACT_TIMEOUT)
    ) u_vsync (
        .clk_i (clk_50mhz_in),
        .rst_i (rst_in),
        .raw_i (vsync_raw_in),
        .sync_o(vsync_out),
        .fall_o(vsync_fall_out),
        .pol_o (vsync_pol_out),
        .act_o (vsync_act_out)
    );

endmodule

// File: tb/tb_sync_conditioner.sv
// Directed bench for sync_conditioner: vector table plus multi-cycle sequences for
// periodic syncs, polarity learning, timeout and mid-pulse reset.
`timescale 1ns/1ps
module tb_sync_conditioner;

    localparam int FL  = 4;
    localparam int TOI = 4000;
    localparam int HP  = 3155;
    localparam int HL  = 347;
    localparam int VP  = 1500;
    localparam int VL  = 150;
    // Ticks from the last filtered edge (inverted hsync fall) to the end of a period.
    localparam int SINCE_EDGE = HP - 1 - (HL + FL + 1);

`ifdef SYNC_POLARITY_AUTO_EN
    localparam logic EXP_POL = 1'b1;
    localparam int   EXP_LOW = HL;
`else
    localparam logic EXP_POL = 1'b0;
    localparam int   EXP_LOW = HP - HL;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic h_raw = 1'b1;
    logic v_raw = 1'b1;
    logic h_out, v_out, h_fall, v_fall, h_pol, v_pol, h_act, v_act;

    int n_pass  = 0;
    int n_total = 0;

    always #10 clk = ~clk;

    sync_conditioner #(
        .FILTER_LEN (FL),
        .ACT_TIMEOUT(TOI)
    ) dut (
        .clk_50mhz_in  (clk),
        .rst_in        (rst),
        .hsync_raw_in  (h_raw),
        .vsync_raw_in  (v_raw),
        .hsync_out     (h_out),
        .vsync_out     (v_out),
        .hsync_fall_out(h_fall),
        .vsync_fall_out(v_fall),
        .hsync_pol_out (h_pol),
        .vsync_pol_out (v_pol),
        .hsync_act_out (h_act),
        .vsync_act_out (v_act)
    );

    typedef struct packed {
        logic h;
        logic v;
        int   n;
        logic h_out;
        logic v_out;
        logic h_fall;
        logic v_fall;
        logic h_act;
        logic v_act;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    initial begin
        logic [7:0] dly;
        int errs, falls, lows;

        // From idle-high on both channels; filtered latency is 2+FL = 6 ticks.
        vecs[0] = '{1'b0, 1'b1, 5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 6,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        repeat (3) tick();
        chk("rst h_out", h_out, 1);
        chk("rst v_out", v_out, 1);
        chk("rst h_fall", h_fall, 0);
        chk("rst pol", {h_pol, v_pol}, 0);
        chk("rst act", {h_act, v_act}, 0);
        rst = 1'b0;

        falls = 0;
        repeat (20) begin
            tick();
            if (h_fall || v_fall) falls++;
        end
        chk("post-rst falls", falls, 0);
        chk("post-rst act", {h_act, v_act}, 0);

        for (int i = 0; i < 9; i++) begin
            h_raw = vecs[i].h;
            v_raw = vecs[i].v;
            repeat (vecs[i].n) tick();
            chk($sformatf("vec%0d h_out", i), h_out, vecs[i].h_out);
            chk($sformatf("vec%0d v_out", i), v_out, vecs[i].v_out);
            chk($sformatf("vec%0d h_fall", i), h_fall, vecs[i].h_fall);
            chk($sformatf("vec%0d v_fall", i), v_fall, vecs[i].v_fall);
            chk($sformatf("vec%0d h_act", i), h_act, vecs[i].h_act);
            chk($sformatf("vec%0d v_act", i), v_act, vecs[i].v_act);
            chk($sformatf("vec%0d pol", i), {h_pol, v_pol}, 0);
        end

        // Active-low hsync: output is the raw waveform delayed 2+FL ticks.
        dly = '1;
        for (int p = 0; p < 4; p++) begin
            errs  = 0;
            falls = 0;
            for (int c = 0; c < HP; c++) begin
                h_raw = (c < HL) ? 1'b0 : 1'b1;
                dly   = {dly[6:0], h_raw};
                tick();
                if (h_out !== dly[5]) errs++;
                if (h_fall) falls++;
            end
            chk($sformatf("hlow p%0d follow errs", p), errs, 0);
            chk($sformatf("hlow p%0d falls", p), falls, 1);
        end
        chk("hlow pol", h_pol, 0);

        // Inverted hsync from a fresh reset.
        h_raw = 1'b0;
        rst   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        lows  = 0;
        falls = 0;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < HP; c++) begin
                h_raw = (c < HL) ? 1'b1 : 1'b0;
                tick();
                if (p == 1 && c == HP - 1) chk("hinv pol after p1", h_pol, 0);
                if (p == 2 && c == FL) chk("hinv pol before rise", h_pol, 0);
                if (p == 2 && c == FL + 1) chk("hinv pol at rise", h_pol, EXP_POL);
                if (p == 3) begin
                    if (!h_out) lows++;
                    if (h_fall) falls++;
                end
            end
        end
        chk("hinv low cycles", lows, EXP_LOW);
        chk("hinv falls", falls, 1);
        chk("hinv act", h_act, 1);

        // Hsync stops: act drops exactly TOI ticks after the last filtered edge.
        repeat (TOI - 1 - SINCE_EDGE) tick();
        chk("timeout act before", h_act, 1);
        tick();
        chk("timeout act", h_act, 0);
        chk("timeout h_out", h_out, 1);
        chk("timeout pol hold", h_pol, EXP_POL);

        // Reset asserted in the middle of a vsync pulse.
        v_raw = 1'b0;
        repeat (20) tick();
        chk("vpulse v_out", v_out, 0);
        chk("vpulse v_act", v_act, 1);
        rst = 1'b1;
        #1;
        chk("async rst v_out", v_out, 1);
        chk("async rst v_fall", v_fall, 0);
        chk("async rst act", {h_act, v_act}, 0);
        chk("async rst pol", {h_pol, v_pol}, 0);
        tick();
        tick();
        rst   = 1'b0;
        falls = 0;
        errs  = 0;
        repeat (30) begin
            tick();
            if (v_fall) falls++;
            if (v_out !== 1'b1) errs++;
        end
        chk("rst mid-pulse falls", falls, 0);
        chk("rst mid-pulse v_out", errs, 0);
        chk("rst mid-pulse v_act", v_act, 0);
        v_raw = 1'b1;
        falls = 0;
        repeat (20) begin
            tick();
            if (v_fall) falls++;
        end
        chk("v release falls", falls, 0);
        chk("v release act", v_act, 1);

        // Vsync with 3-cycle glitches mid-frame; model is the clean waveform.
        dly = '1;
        for (int p = 0; p < 4; p++) begin
            errs  = 0;
            falls = 0;
            for (int c = 0; c < VP; c++) begin
                logic clean;
                clean = (c < VL) ? 1'b0 : 1'b1;
                v_raw = (c >= 700 && c < 703) ? 1'b0 : clean;
                dly   = {dly[6:0], clean};
                tick();
                if (v_out !== dly[5]) errs++;
                if (v_fall) falls++;
            end
            chk($sformatf("vsync p%0d follow errs", p), errs, 0);
            chk($sformatf("vsync p%0d falls", p), falls, 1);
        end
        chk("vsync pol", v_pol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
